// File: rtl/lab3_serial_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// lab3_serial_tx : parallel-to-serial transmitter with optional parity bit
// Revision 1.0 - initial release
// ============================================================================
module lab3_serial_tx #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int PARITY    = 0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] Din,
  output logic             Dout,
  output logic             Valid,
  output logic             Busy,
  output logic             Done
);

  localparam int c_NLEN = WIDTH + ((PARITY != 0) ? 1 : 0);
  localparam int c_CW   = $clog2(WIDTH + 2);
  localparam logic [c_CW-1:0] c_CNT_LOAD = c_CW'(c_NLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_NLEN-1:0] r_frame;
  logic [c_NLEN-1:0] w_frame_nxt;
  logic [c_NLEN-1:0] w_load;
  logic [c_CW-1:0]   r_cnt;
  logic [c_CW-1:0]   w_cnt_nxt;
  logic              r_dout;
  logic              w_dout_nxt;
  logic              r_valid;
  logic              w_valid_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic [WIDTH-1:0]  w_data;

  // w_data[0] is always the first bit on the wire, whatever the bit order
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign w_data[i] = Din[WIDTH-1-i];
      end
    end else begin : g_lsb_first
      assign w_data = Din;
    end

    if (PARITY == 0) begin : g_no_parity
      assign w_load = w_data;
    end else if (PARITY == 1) begin : g_even_parity
      assign w_load = {^Din, w_data};
    end else begin : g_odd_parity
      assign w_load = {~^Din, w_data};
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_frame <= '0;
      r_cnt   <= '0;
      r_dout  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_frame <= w_frame_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dout  <= w_dout_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Frame register holds the bits still to be sent; bit 0 goes out next
  always_comb begin
    w_state_nxt = r_state;
    w_frame_nxt = r_frame;
    w_cnt_nxt   = r_cnt;
    w_dout_nxt  = 1'b0;
    w_valid_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_frame_nxt = w_load >> 1;
          w_cnt_nxt   = c_CNT_LOAD;
          w_dout_nxt  = w_load[0];
          w_valid_nxt = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == '0) begin
          w_frame_nxt = '0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_frame_nxt = r_frame >> 1;
          w_cnt_nxt   = r_cnt - 1'b1;
          w_dout_nxt  = r_frame[0];
          w_valid_nxt = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign Dout  = r_dout;
  assign Valid = r_valid;
  assign Done  = r_done;
  assign Busy  = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lab3_serial_tx.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench: three transmitter configurations share one random stimulus
// stream; a frame-level model predicts every frame and per-cycle handshake.
module tb_lab3_serial_tx;

  typedef struct {
    logic [15:0] bits;
    int          len;
    int          done_cyc;
  } frame_t;

  logic       Clk   = 1'b0;
  logic       Rst   = 1'b1;
  logic       Start = 1'b0;
  logic [7:0] Din   = 8'h00;
  logic [2:0] dout_v, valid_v, busy_v, done_v;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  int nlen[3] = '{8, 9, 9};
  int msbf[3] = '{1, 0, 1};
  int par[3]  = '{0, 1, 2};

  frame_t      sbq[3][$];
  int          acc[3];
  bit          alive[3];
  logic [15:0] cur[3];
  logic        exp_valid[3], exp_busy[3], exp_done[3], exp_dout[3];
  logic [15:0] col[3];
  int          ncol[3];

  always #5 Clk = ~Clk;

  lab3_serial_tx #(.WIDTH(8), .MSB_FIRST(1), .PARITY(0)) u_d0 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Din(Din),
    .Dout(dout_v[0]), .Valid(valid_v[0]), .Busy(busy_v[0]), .Done(done_v[0]));
  lab3_serial_tx #(.WIDTH(8), .MSB_FIRST(0), .PARITY(1)) u_d1 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Din(Din),
    .Dout(dout_v[1]), .Valid(valid_v[1]), .Busy(busy_v[1]), .Done(done_v[1]));
  lab3_serial_tx #(.WIDTH(8), .MSB_FIRST(1), .PARITY(2)) u_d2 (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Din(Din),
    .Dout(dout_v[2]), .Valid(valid_v[2]), .Busy(busy_v[2]), .Done(done_v[2]));

  function automatic frame_t make_frame(input int d, input logic [7:0] din, input int c);
    frame_t f;
    int ones;
    ones   = 0;
    f.bits = '0;
    for (int i = 0; i < 8; i++) begin
      f.bits[i] = (msbf[d] != 0) ? din[7-i] : din[i];
      ones += int'(din[i]);
    end
    f.len = 8;
    if (par[d] != 0) begin
      f.bits[8] = (par[d] == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
      f.len = 9;
    end
    f.done_cyc = c + f.len;
    return f;
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, d, cyc, act, exp);
    end
  endtask

  // Reference model: one frame in flight per config, accepted when idle
  always @(posedge Clk) begin
    frame_t f;
    frame_t junk;
    int off;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (Rst) begin
        if (alive[d] && cyc <= acc[d] + nlen[d] && sbq[d].size() > 0)
          junk = sbq[d].pop_back();
        alive[d] = 1'b0;
      end else if (!alive[d] || cyc >= acc[d] + nlen[d] + 2) begin
        alive[d] = 1'b0;
        if (Start) begin
          f = make_frame(d, Din, cyc);
          sbq[d].push_back(f);
          cur[d]   = f.bits;
          acc[d]   = cyc;
          alive[d] = 1'b1;
        end
      end
      off = cyc - acc[d];
      exp_valid[d] = alive[d] && off < nlen[d];
      exp_done[d]  = alive[d] && off == nlen[d];
      exp_busy[d]  = alive[d] && off <= nlen[d];
      exp_dout[d]  = 1'b0;
      if (exp_valid[d]) exp_dout[d] = cur[d][off];
    end
  end

  // Monitor: per-cycle handshake checks, frame comparison on every Done
  always @(posedge Clk) begin
    frame_t f;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("valid", d, 32'(valid_v[d]), 32'(exp_valid[d]));
      chk("busy",  d, 32'(busy_v[d]),  32'(exp_busy[d]));
      chk("done",  d, 32'(done_v[d]),  32'(exp_done[d]));
      chk("dout",  d, 32'(dout_v[d]),  32'(exp_dout[d]));
      if (Rst) begin
        ncol[d] = 0;
        col[d]  = '0;
      end else begin
        if (valid_v[d] === 1'b1) begin
          if (ncol[d] < 16) col[d][ncol[d]] = dout_v[d];
          ncol[d]++;
        end
        if (done_v[d] === 1'b1) begin
          chk("sb_nonempty_at_done", d, 32'(sbq[d].size() > 0), 32'd1);
          if (sbq[d].size() > 0) begin
            f = sbq[d].pop_front();
            chk("frame_len",  d, 32'(ncol[d]), 32'(f.len));
            chk("frame_bits", d, 32'(col[d]),  32'(f.bits));
            chk("done_cycle", d, 32'(cyc),     32'(f.done_cyc));
          end
          ncol[d] = 0;
          col[d]  = '0;
        end
      end
    end
  end

  task automatic step(input logic r, input logic s, input logic [7:0] dn);
    Rst   = r;
    Start = s;
    Din   = dn;
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    idle(2);

    // single frame of 8'h1C
    step(1'b0, 1'b1, 8'h1C);
    idle(14);

    // Start and Din disturbed mid-frame, then Start held for repeated frames
    step(1'b0, 1'b1, 8'h1C);
    idle(2);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 8'($urandom));
    idle(14);

    // reset on the 4th frame bit, then a clean frame
    step(1'b0, 1'b1, 8'h1C);
    idle(2);
    step(1'b1, 1'b0, 8'h00);
    idle(4);
    step(1'b0, 1'b1, 8'hA5);
    idle(14);

    // reset and start together
    step(1'b1, 1'b1, 8'h77);
    idle(4);

    for (int i = 0; i < 800; i++)
      step(1'b0 | ($urandom_range(0, 59) == 0),
           ($urandom_range(0, 2) != 0),
           8'($urandom));
    idle(16);

    for (int d = 0; d < 3; d++)
      chk("sb_drained", d, 32'(sbq[d].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
